// File: rtl/instr_adder_pkg.sv
// Shared constants for the instrumented Sklansky adder wrapper: operand width,
// register select codes, LA3 control bit positions and mask reset values.
package instr_adder_pkg;

   localparam int WIDTH = 32;

   localparam logic [2:0] SEL_A    = 3'd0;
   localparam logic [2:0] SEL_B    = 3'd1;
   localparam logic [2:0] SEL_EXT  = 3'd2;
   localparam logic [2:0] SEL_RING = 3'd3;
   localparam logic [2:0] SEL_SOUT = 3'd4;

   localparam int CTL_SEL_LSB = 32'sd0;
   localparam int CTL_SEL_MSB = 32'sd2;
   localparam int CTL_WR      = 32'sd3;
   localparam int CTL_RUN     = 32'sd4;
   localparam int CTL_CLR     = 32'sd5;

   localparam logic [WIDTH-1:0] EXT_B_RST  = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] RING_B_RST = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] SOUT_B_RST = {WIDTH{1'b1}};

   // Ring bits take the inverted chain, otherwise an enabled external bit, else 0.
   function automatic logic [WIDTH-1:0] effective_a(
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] ext_b,
      input logic [WIDTH-1:0] ring_b,
      input logic             chain
   );
      return (~ring_b & {WIDTH{~chain}}) | (ring_b & ~ext_b & a);
   endfunction

endpackage

// File: rtl/instrumented_adder_sklansky_wrapper_adder.sv
// Combinational Sklansky parallel-prefix adder, carry-in 0.
module adder_sklansky #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   localparam int LEVELS = $clog2(WIDTH);

   // Prefix tree: at level l every bit with index bit l set merges the last bit of the lower half-block.
   always_comb begin
      logic [WIDTH-1:0] g_v [0:LEVELS];
      logic [WIDTH-1:0] p_v [0:LEVELS];
      logic [WIDTH-1:0] hs_v;
      int               j_v;
      j_v    = 32'sd0;
      hs_v   = a ^ b;
      g_v[0] = a & b;
      p_v[0] = hs_v;
      for (int l = 32'sd0; l < LEVELS; l++) begin
         for (int i = 32'sd0; i < WIDTH; i++) begin
            if (((i >> l) & 32'sd1) == 32'sd1) begin
               j_v          = ((i >> l) << l) - 32'sd1;
               g_v[l+1][i]  = g_v[l][i] | (p_v[l][i] & g_v[l][j_v]);
               p_v[l+1][i]  = p_v[l][i] & p_v[l][j_v];
            end else begin
               g_v[l+1][i]  = g_v[l][i];
               p_v[l+1][i]  = p_v[l][i];
            end
         end
      end
      sum   = hs_v ^ {g_v[LEVELS][WIDTH-2:0], 1'b0};
      carry = g_v[LEVELS][WIDTH-1];
   end

endmodule

// File: rtl/instrumented_adder_sklansky_wrapper.sv
// User-project wrapper: LA-programmed operand/mask registers, Sklansky adder,
// chain-bit ring, toggle counter and active-gated outputs.
module instrumented_adder_sklansky_wrapper
   import instr_adder_pkg::*;
#(
   parameter int IO_PADS   = 38,
   parameter int CHAIN_PAD = 8
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   input  logic               active,
   input  logic [IO_PADS-1:0] io_in,
   output logic [IO_PADS-1:0] io_out,
   output logic [IO_PADS-1:0] io_oeb,
   input  logic [WIDTH-1:0]   la1_data_in,
   output logic [WIDTH-1:0]   la1_data_out,
   input  logic [WIDTH-1:0]   la1_oenb,
   input  logic [WIDTH-1:0]   la2_data_in,
   output logic [WIDTH-1:0]   la2_data_out,
   input  logic [WIDTH-1:0]   la2_oenb,
   input  logic [WIDTH-1:0]   la3_data_in,
   output logic [WIDTH-1:0]   la3_data_out,
   input  logic [WIDTH-1:0]   la3_oenb
);

   logic [WIDTH-1:0] a_input_r, b_input_r, ext_b_r, ring_b_r, sout_b_r;
   logic [WIDTH-1:0] sum_r, counter_r;
   logic             carry_r, chain_d_r, wr_prev_r;
   logic [2:0]       sel_s;
   logic             wr_s, run_s, clr_s, wr_pulse_s;
   logic [WIDTH-1:0] a_eff_s, sum_s;
   logic             carry_s;
   logic             chain_out;
   logic             unused_s;

   assign sel_s      = la3_data_in[CTL_SEL_MSB:CTL_SEL_LSB];
   assign wr_s       = la3_data_in[CTL_WR];
   assign run_s      = la3_data_in[CTL_RUN];
   assign clr_s      = la3_data_in[CTL_CLR];
   assign wr_pulse_s = wr_s & ~wr_prev_r;
   assign unused_s   = ^{io_in, la1_oenb, la2_data_in, la2_oenb, la3_oenb,
                         la3_data_in[WIDTH-1:CTL_CLR+1]};

   assign a_eff_s   = effective_a(a_input_r, ext_b_r, ring_b_r, chain_out);
   assign chain_out = ^(sum_r & ~sout_b_r);

   adder_sklansky #(.WIDTH(WIDTH)) u_adder (
      .a     (a_eff_s),
      .b     (b_input_r),
      .sum   (sum_s),
      .carry (carry_s)
   );

   // Register file writes on the first cycle wr is seen high.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wr_prev_r <= 1'b0;
         a_input_r <= {WIDTH{1'b0}};
         b_input_r <= {WIDTH{1'b0}};
         ext_b_r   <= EXT_B_RST;
         ring_b_r  <= RING_B_RST;
         sout_b_r  <= SOUT_B_RST;
      end else begin
         wr_prev_r <= wr_s;
         if (wr_pulse_s) begin
            case (sel_s)
               SEL_A:    a_input_r <= la1_data_in;
               SEL_B:    b_input_r <= la1_data_in;
               SEL_EXT:  ext_b_r   <= la1_data_in;
               SEL_RING: ring_b_r  <= la1_data_in;
               SEL_SOUT: sout_b_r  <= la1_data_in;
               default:  ;
            endcase
         end
      end
   end

   // Sum capture and chain toggle counter; clr beats run.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         sum_r     <= {WIDTH{1'b0}};
         carry_r   <= 1'b0;
         chain_d_r <= 1'b0;
         counter_r <= {WIDTH{1'b0}};
      end else begin
         sum_r     <= sum_s;
         carry_r   <= carry_s;
         chain_d_r <= chain_out;
         if (clr_s) begin
            counter_r <= {WIDTH{1'b0}};
         end else if (run_s && (chain_out != chain_d_r)) begin
            counter_r <= counter_r + {{(WIDTH-1){1'b0}}, 1'b1};
         end
      end
   end

   // Output gating: quiet pads and LA lines whenever the block is deselected.
   always_comb begin
      io_out       = {IO_PADS{1'b0}};
      io_oeb       = {IO_PADS{1'b1}};
      la1_data_out = {WIDTH{1'b0}};
      la2_data_out = {WIDTH{1'b0}};
      la3_data_out = {WIDTH{1'b0}};
      if (active) begin
         io_out[CHAIN_PAD] = chain_out;
         io_oeb[CHAIN_PAD] = 1'b0;
         la1_data_out      = sum_r;
         la2_data_out      = counter_r;
         la3_data_out      = {{(WIDTH-3){1'b0}}, run_s, carry_r, chain_out};
      end else begin
         io_out[CHAIN_PAD] = 1'b0;
         io_oeb[CHAIN_PAD] = 1'b1;
      end
   end

endmodule

// File: tb/tb_instrumented_adder_sklansky_wrapper.sv
// Self-checking bench: directed vectors, ring/counter sequences and random
// control traffic compared against a cycle model of the LA-programmed wrapper.
module tb_instrumented_adder_sklansky_wrapper;

   logic        clk = 1'b0;
   logic        rst;
   logic        active;
   logic [37:0] io_in, io_out, io_oeb;
   logic [31:0] la1_in, la1_out, la2_out, la3_out, la3_in;
   logic [31:0] la1_oenb, la2_in, la2_oenb, la3_oenb;
   logic [2:0]  t_sel;
   logic        t_wr, t_run, t_clr;

   int n_tests = 0;
   int n_fail  = 0;

   // model state
   logic [31:0] m_a, m_b, m_ext, m_ring, m_sout, m_sum, m_cnt;
   logic        m_carry, m_chain_d, m_wr_prev;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] sum;
      logic        carry;
   } add_vec_t;
   add_vec_t vecs [6];

   assign la3_in = {26'd0, t_clr, t_run, t_wr, t_sel};

   always #5 clk = ~clk;

   instrumented_adder_sklansky_wrapper dut (
      .wb_clk_i     (clk),
      .wb_rst_i     (rst),
      .active       (active),
      .io_in        (io_in),
      .io_out       (io_out),
      .io_oeb       (io_oeb),
      .la1_data_in  (la1_in),
      .la1_data_out (la1_out),
      .la1_oenb     (la1_oenb),
      .la2_data_in  (la2_in),
      .la2_data_out (la2_out),
      .la2_oenb     (la2_oenb),
      .la3_data_in  (la3_in),
      .la3_data_out (la3_out),
      .la3_oenb     (la3_oenb)
   );

   function automatic logic model_chain();
      logic [31:0] tapped;
      tapped = m_sum & ~m_sout;
      return ^tapped;
   endfunction

   task automatic model_reset();
      m_a = 32'd0; m_b = 32'd0; m_ext = 32'd0;
      m_ring = 32'hFFFF_FFFF; m_sout = 32'hFFFF_FFFF;
      m_sum = 32'd0; m_cnt = 32'd0;
      m_carry = 1'b0; m_chain_d = 1'b0; m_wr_prev = 1'b0;
   endtask

   task automatic model_step();
      logic        ch;
      logic [31:0] aeff;
      logic [32:0] total;
      ch = model_chain();
      for (int i = 0; i < 32; i++) begin
         if (!m_ring[i])     aeff[i] = ~ch;
         else if (!m_ext[i]) aeff[i] = m_a[i];
         else                aeff[i] = 1'b0;
      end
      total = {1'b0, aeff} + {1'b0, m_b};
      if (t_clr)                            m_cnt = 32'd0;
      else if (t_run && (ch != m_chain_d))  m_cnt = m_cnt + 32'd1;
      m_chain_d = ch;
      if (t_wr && !m_wr_prev) begin
         case (t_sel)
            3'd0: m_a    = la1_in;
            3'd1: m_b    = la1_in;
            3'd2: m_ext  = la1_in;
            3'd3: m_ring = la1_in;
            3'd4: m_sout = la1_in;
            default: ;
         endcase
      end
      m_wr_prev = t_wr;
      m_sum     = total[31:0];
      m_carry   = total[32];
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all();
      logic ch;
      ch = model_chain();
      if (active) begin
         check("la1", {32'd0, la1_out}, {32'd0, m_sum});
         check("la2", {32'd0, la2_out}, {32'd0, m_cnt});
         check("la3", {32'd0, la3_out}, {32'd0, 29'd0, t_run, m_carry, ch});
         check("io_out", {26'd0, io_out}, {26'd0, 38'd0} | ({63'd0, ch} << 8));
         check("io_oeb", {26'd0, io_oeb}, {26'd0, ~(38'd1 << 8)});
      end else begin
         check("la1_q", {32'd0, la1_out}, 64'd0);
         check("la2_q", {32'd0, la2_out}, 64'd0);
         check("la3_q", {32'd0, la3_out}, 64'd0);
         check("io_out_q", {26'd0, io_out}, 64'd0);
         check("io_oeb_q", {26'd0, io_oeb}, {26'd0, {38{1'b1}}});
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset();
      else     model_step();
      #1;
      check_all();
   endtask

   task automatic write_reg(input logic [2:0] sel, input logic [31:0] data);
      t_sel = sel; t_wr = 1'b0; tick();
      t_wr = 1'b1; la1_in = data; tick();
      t_wr = 1'b0; tick();
   endtask

   initial begin
      logic prev_chain;
      vecs[0] = '{32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 1'b0};
      vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
      vecs[2] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
      vecs[3] = '{32'h1234_5678, 32'h8765_4321, 32'h9999_9999, 1'b0};
      vecs[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0};
      vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1};

      rst = 1'b1; active = 1'b1; io_in = 38'd0;
      la1_in = 32'd0; la1_oenb = 32'd0; la2_in = 32'd0; la2_oenb = 32'd0; la3_oenb = 32'd0;
      t_sel = 3'd0; t_wr = 1'b0; t_run = 1'b0; t_clr = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_la1", {32'd0, la1_out}, 64'd0);
      check("rst_la2", {32'd0, la2_out}, 64'd0);
      check("rst_la3", {32'd0, la3_out}, 64'd0);
      check("rst_io_out", {26'd0, io_out}, 64'd0);
      check("rst_io_oeb", {26'd0, io_oeb}, {26'd0, 38'h3F_FFFF_FEFF});
      rst = 1'b0;

      // adder vectors
      for (int v = 0; v < 6; v++) begin
         write_reg(3'd0, vecs[v].a);
         write_reg(3'd1, vecs[v].b);
         tick();
         check("vec_sum", {32'd0, la1_out}, {32'd0, vecs[v].sum});
         check("vec_carry", {63'd0, la3_out[1]}, {63'd0, vecs[v].carry});
      end

      // single sum tap
      write_reg(3'd0, 32'd1);
      write_reg(3'd1, 32'd0);
      write_reg(3'd4, 32'hFFFF_FFFE);
      tick();
      check("tap_chain", {63'd0, la3_out[0]}, 64'd1);
      check("tap_pad", {63'd0, io_out[8]}, 64'd1);

      // ring oscillation and counter
      write_reg(3'd0, 32'd0);
      write_reg(3'd1, 32'd0);
      write_reg(3'd3, 32'hFFFF_FFFE);
      t_run = 1'b1;
      prev_chain = la3_out[0];
      for (int c = 0; c < 10; c++) begin
         tick();
         check("ring_toggle", {63'd0, la3_out[0]}, {63'd0, ~prev_chain});
         prev_chain = la3_out[0];
      end
      check("ring_count10", {32'd0, la2_out}, 64'd10);
      t_clr = 1'b1; tick();
      check("clr_count", {32'd0, la2_out}, 64'd0);
      t_clr = 1'b0;

      // outputs quiet while ring keeps counting
      active = 1'b0;
      repeat (5) tick();
      check("quiet_oeb", {26'd0, io_oeb}, {26'd0, {38{1'b1}}});
      active = 1'b1;
      #1;
      check("count_kept", {32'd0, la2_out}, 64'd5);

      // wr held high: only the first data word lands
      t_run = 1'b0;
      write_reg(3'd3, 32'hFFFF_FFFF);
      write_reg(3'd4, 32'hFFFF_FFFF);
      write_reg(3'd1, 32'd0);
      t_sel = 3'd0; t_wr = 1'b0; tick();
      t_wr = 1'b1; la1_in = 32'h1111_0000; tick();
      la1_in = 32'h2222_0000; tick();
      la1_in = 32'h3333_0000; tick();
      t_wr = 1'b0; tick();
      check("wr_hold", {32'd0, la1_out}, 64'h1111_0000);

      // random control traffic
      for (int r = 0; r < 400; r++) begin
         t_sel  = 3'($urandom_range(0, 7));
         t_wr   = 1'($urandom_range(0, 1));
         t_run  = ($urandom_range(0, 3) != 0);
         t_clr  = ($urandom_range(0, 15) == 0);
         active = ($urandom_range(0, 7) != 0);
         case ($urandom_range(0, 3))
            0:       la1_in = 32'd0;
            1:       la1_in = 32'hFFFF_FFFF;
            default: la1_in = $urandom;
         endcase
         tick();
      end

      // asynchronous reset in the middle of a ring run
      active = 1'b1; t_clr = 1'b0; t_run = 1'b0;
      write_reg(3'd2, 32'd0);
      write_reg(3'd3, 32'hFFFF_FFFE);
      write_reg(3'd4, 32'hFFFF_FFFE);
      t_run = 1'b1;
      repeat (6) tick();
      rst = 1'b1;
      #1;
      model_reset();
      check("midrst_la1", {32'd0, la1_out}, 64'd0);
      check("midrst_la2", {32'd0, la2_out}, 64'd0);
      check_all();
      repeat (2) tick();
      rst = 1'b0;
      repeat (4) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
